alu_cmd_issuer: RTL and testbench

Upstream command stage for the simple ALU. Accepts operand/opcode commands over a valid/ready port, buffers them in a small FIFO, and drives the ALU start/done handshake one command at a time. Returns each result, or a timeout error, over a valid/ready response port. Sits directly in front of the ALU and drives its `start`, `op`, `a` and `b` inputs.

---
 rtl/simplealu_pkg.sv | 10 +
 rtl/alu_cmd_fifo.sv | 43 ++++
 rtl/alu_cmd_issuer.sv | 134 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplealu_pkg.sv
// simplealu_pkg: opcode type shared by the simple ALU and its command issuer
package simplealu_pkg;
  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4
  } op_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with occupancy count and wrapping pointers
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 19
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  // storage write; contents need no reset since the level gates every read
  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr] <= wdata;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop) r_rd <= r_rd + AW'(1);
      if (push && !pop) r_level <= r_level + 1'b1;
      else if (!push && pop) r_level <= r_level - 1'b1;
    end
  end
  assign head  = r_mem[r_rd];
  assign full  = (r_level == L_FULL);
  assign empty = (r_level == '0);
  assign level = r_level;
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands and runs the ALU start/done handshake one command at a time
module alu_cmd_issuer
  import simplealu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  op_t                    cmd_op,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  output logic                   alu_start,
  output op_t                    alu_op,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_result,
  output logic                   rsp_error,
  output logic [$clog2(DEPTH):0] level
);
  localparam int W = $bits(op_t) + 16;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  state_t      r_state, w_state_nxt;
  op_t         r_op, w_op_nxt;
  logic [7:0]  r_a, w_a_nxt;
  logic [7:0]  r_b, w_b_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_res, w_res_nxt;
  logic        r_err, w_err_nxt;
  logic        r_start;
  logic        r_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [W-1:0] w_head;
  op_t         w_head_op;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_head_op = op_t'(w_head[W-1:16]);

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // next state, operand capture, wait counter and response capture
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop = 1'b1;
        if (w_head_op == NO_OP) begin
          w_state_nxt = S_RESP;
          w_res_nxt   = '0;
          w_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_BUSY;
          w_op_nxt    = w_head_op;
          w_a_nxt     = w_head[15:8];
          w_b_nxt     = w_head[7:0];
          w_cnt_nxt   = '0;
        end
      end
      S_BUSY: if (alu_done) begin
        w_state_nxt = S_RESP;
        w_res_nxt   = alu_result;
        w_err_nxt   = 1'b0;
      end else if (r_cnt == 8'(TIMEOUT - 1)) begin
        w_state_nxt = S_RESP;
        w_res_nxt   = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state and registered outputs; start/valid are decoded from the next state so they leave flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= NO_OP;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_err   <= w_err_nxt;
      r_start <= (w_state_nxt == S_BUSY);
      r_valid <= (w_state_nxt == S_RESP);
    end
  end

  assign alu_start  = r_start;
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_valid  = r_valid;
  assign rsp_result = r_res;
  assign rsp_error  = r_err;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench with a behavioural ALU and randomized command streams
module tb_alu_cmd_issuer;
  import simplealu_pkg::*;
  localparam int DEPTH = 4;
  localparam int TO = 31;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  op_t         cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        alu_start;
  op_t         alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_error;
  logic [2:0]  level;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat = 3;
  bit   done_mode = 1'b1;
  bit   rand_rdy = 1'b0;
  bit   rdy_force = 1'b1;
  int   starts = 0;
  int   pp_cnt = 0;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .level      (level)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] alu_fn(input op_t op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADD:     return 16'(a) + 16'(b);
      AND:     return {8'h00, a & b};
      XOR:     return {8'h00, a ^ b};
      MUL:     return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic exp_t model(input op_t op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.res = 16'h0000;
    e.err = 1'b0;
    if (op != NO_OP) begin
      if (done_mode) e.res = alu_fn(op, a, b);
      else e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  task automatic send(input op_t op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(negedge clock);
    while (!cmd_ready && t < 1000) begin
      t++;
      @(negedge clock);
    end
    if (cmd_ready) q.push_back(model(op, a, b));
    else fail("cmd_accept_timeout");
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(q.size() == 0 && !alu_start && !rsp_valid && level == 0) && t < 2000);
    if (t >= 2000) fail("idle_timeout");
    @(posedge clock);
    #1;
  endtask

  // response consumer: random or forced ready, updated away from the main driver's slot
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // behavioural ALU: done after lat start cycles, or never (with a late stray done) in timeout mode
  initial begin
    int run = 0;
    bit pend = 0;
    op_t s_op;
    logic [7:0] s_a, s_b;
    alu_done = 1'b0;
    alu_result = 16'h0000;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        run = 0;
        pend = 0;
        alu_done = 1'b0;
        continue;
      end
      if (pend) begin
        chk("done_to_rsp", {30'd0, alu_start, rsp_valid}, 32'd1);
        pend = 0;
      end
      alu_done = 1'b0;
      if (alu_start) begin
        if (run == 0) begin
          s_op = alu_op;
          s_a = alu_a;
          s_b = alu_b;
          starts++;
        end else begin
          chk("alu_operand_hold", {13'd0, alu_op, alu_a, alu_b}, {13'd0, s_op, s_a, s_b});
        end
        run++;
        if (done_mode && run == lat) begin
          alu_done = 1'b1;
          alu_result = alu_fn(alu_op, alu_a, alu_b);
          pend = 1;
        end
      end else if (run > 0) begin
        chk("start_length", run, done_mode ? lat : TO);
        run = 0;
        if (!done_mode) begin
          alu_done = 1'b1;
          alu_result = 16'hDEAD;
        end
      end
    end
  end

  // monitor: scoreboard pops on each response handshake, plus hold and ready invariants
  initial begin
    bit hold = 0;
    bit pushing = 0;
    logic [15:0] h_res;
    logic h_err;
    logic [2:0] lvl0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold = 0;
        pushing = 0;
        continue;
      end
      chk("cmd_ready_vs_level", {31'd0, cmd_ready}, {31'd0, level != 3'(DEPTH)});
      if (pushing && level == lvl0) pp_cnt++;
      pushing = cmd_valid && cmd_ready;
      lvl0 = level;
      if (hold) chk("rsp_hold", {15'd0, rsp_valid, rsp_result, rsp_error}, {15'd0, 1'b1, h_res, h_err});
      hold = 0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          if (q.size() == 0) fail("unexpected_response");
          else begin
            e = q.pop_front();
            chk("rsp", {15'd0, rsp_result, rsp_error}, {15'd0, e.res, e.err});
          end
        end else begin
          hold = 1;
          h_res = rsp_result;
          h_err = rsp_error;
        end
      end
    end
  end

  initial begin
    int s0;
    int t;
    cmd_valid = 1'b0;
    cmd_op = NO_OP;
    cmd_a = 8'h00;
    cmd_b = 8'h00;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset_alu_start", {31'd0, alu_start}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_result", {16'd0, rsp_result}, 32'd0);
    chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("reset_level", {29'd0, level}, 32'd0);
    chk("reset_alu_op", {29'd0, alu_op}, 32'd0);
    chk("reset_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    // ADD with three-cycle ALU
    lat = 3;
    send(ADD, 8'h12, 8'h34);
    @(posedge clock);
    #1;
    chk("start_latency", {31'd0, alu_start}, 32'd1);
    wait_idle();
    // MUL at the top of the operand range, then a NO_OP bypassing the ALU
    send(MUL, 8'hFF, 8'hFF);
    wait_idle();
    s0 = starts;
    send(NO_OP, 8'h55, 8'h66);
    @(posedge clock);
    #1;
    chk("noop_latency", {31'd0, rsp_valid}, 32'd1);
    wait_idle();
    chk("noop_no_start", starts, s0);
    // fill the FIFO while the consumer stalls
    rdy_force = 1'b0;
    for (int i = 0; i < 5; i++) send(ADD, 8'(i * 17), 8'(i + 1));
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (8) @(posedge clock);
    #1;
    rdy_force = 1'b1;
    wait_idle();
    // ALU that never answers, then normal operation resumes
    done_mode = 1'b0;
    send(ADD, 8'h01, 8'h02);
    wait_idle();
    done_mode = 1'b1;
    send(XOR, 8'hAA, 8'h55);
    wait_idle();
    // reset while busy with two commands still queued
    lat = 20;
    for (int i = 0; i < 3; i++) send(ADD, 8'(i), 8'h10);
    t = 0;
    while (!alu_start && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!alu_start) fail("busy_wait_timeout");
    #2 reset = 1'b0;
    #1;
    chk("midreset_alu_start", {31'd0, alu_start}, 32'd0);
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_level", {29'd0, level}, 32'd0);
    q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    lat = 3;
    repeat (40) @(posedge clock);
    #1;
    chk("post_reset_quiet", {30'd0, rsp_valid, alu_start}, 32'd0);
    // full-rate XOR stream wrapping the FIFO pointers
    lat = 1;
    s0 = pp_cnt;
    for (int i = 0; i < 10; i++) send(XOR, 8'hF0, 8'h0F);
    wait_idle();
    chk("push_pop_same_cycle", {31'd0, pp_cnt > s0}, 32'd1);
    // randomized commands, latencies and consumer stalls
    rand_rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      lat = $urandom_range(1, 6);
      for (int i = 0; i < 15; i++) begin
        send(op_t'(3'($urandom_range(0, 4))), 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock);
          #1;
        end
      end
      wait_idle();
    end
    rand_rdy = 1'b0;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
